// File: rtl/sap1_mem_responder_pkg.sv
// Shared types and helpers for the SAP-1 memory responder.
// Holds the responder FSM states and the even-parity helper.
package sap1_mem_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } mem_state_e;

    localparam int PAR_MAX_W = 64;

    function automatic logic even_parity(input logic [PAR_MAX_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/sap1_mem_responder_if.sv
// Controller <-> memory responder bus and handshake bundle.
// The controller side uses master, the responder uses slave.
interface sap1_mem_responder_if #(
    parameter int DATA_WIDTH = 16
);
    logic [DATA_WIDTH-1:0] bus_data;
    logic                  addr_reg_en;
    logic                  data_reg_en;
    logic                  mem_wen;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  mem_rvalid;
    logic                  mem_busy;
    logic                  mem_error;

    modport master (
        output bus_data, addr_reg_en, data_reg_en, mem_wen,
        input  mem_rdata, mem_rvalid, mem_busy, mem_error
    );

    modport slave (
        input  bus_data, addr_reg_en, data_reg_en, mem_wen,
        output mem_rdata, mem_rvalid, mem_busy, mem_error
    );
endinterface

// File: rtl/sap1_mem_responder_ram.sv
// Single-port synchronous RAM; read data registered, held while en=0.
// Contents are never reset.
module sap1_mem_responder_ram #(
    parameter int AW = 8,
    parameter int W  = 16
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata
);
    logic [W-1:0] mem_q [2**AW];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem_q[addr] <= wdata;
            end else begin
                rdata <= mem_q[addr];
            end
        end
    end
endmodule

// File: rtl/sap1_mem_responder.sv
// SAP-1 memory responder: MAR/MDR, read-latency FSM and RAM.
// Define SAP1_MEM_PARITY_EN to store and check an even-parity bit.
module sap1_mem_responder
    import sap1_mem_responder_pkg::*;
#(
    parameter int ADDR_WIDTH   = 8,
    parameter int DATA_WIDTH   = 16,
    parameter int READ_LATENCY = 1
) (
    input  logic                clk,
    input  logic                a_reset_n,
    sap1_mem_responder_if.slave bus
);
`ifdef SAP1_MEM_PARITY_EN
    localparam int RAM_W = DATA_WIDTH + 1;
`else
    localparam int RAM_W = DATA_WIDTH;
`endif
    localparam logic [1:0] CNT_LAST = 2'(READ_LATENCY - 1);

    mem_state_e            state_q;
    logic [1:0]            cnt_q;
    logic [ADDR_WIDTH-1:0] mar_q, mar_d;
    logic [DATA_WIDTH-1:0] mdr_q, mdr_d;
    logic [DATA_WIDTH-1:0] wt_q;
    logic                  rvalid_q, busy_q, sel_ram_q;
    logic                  ram_we, ram_re;
    logic [RAM_W-1:0]      ram_wdata, ram_rdata;

    assign mar_d = bus.addr_reg_en ? bus.bus_data[ADDR_WIDTH-1:0] : mar_q;
    assign mdr_d = bus.data_reg_en ? bus.bus_data : mdr_q;

    always_ff @(posedge clk or negedge a_reset_n) begin
        if (!a_reset_n) begin
            mar_q <= '0;
            mdr_q <= '0;
        end else begin
            mar_q <= mar_d;
            mdr_q <= mdr_d;
        end
    end

    // RAM is only touched on the commit edge of a write or the final
    // edge of a read, so the single port never sees both at once.
    assign ram_we = (state_q == ST_WRITE);
    assign ram_re = (state_q == ST_READ) && !bus.mem_wen &&
                    !bus.addr_reg_en && (cnt_q == CNT_LAST);

`ifdef SAP1_MEM_PARITY_EN
    assign ram_wdata = {even_parity(PAR_MAX_W'(mdr_q)), mdr_q};
    assign bus.mem_error = sel_ram_q &&
        (ram_rdata[DATA_WIDTH] !=
         even_parity(PAR_MAX_W'(ram_rdata[DATA_WIDTH-1:0])));
`else
    assign ram_wdata     = mdr_q;
    assign bus.mem_error = 1'b0;
`endif

    sap1_mem_responder_ram #(
        .AW (ADDR_WIDTH),
        .W  (RAM_W)
    ) u_ram (
        .clk   (clk),
        .en    (ram_we | ram_re),
        .we    (ram_we),
        .addr  (mar_q),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or negedge a_reset_n) begin
        if (!a_reset_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            rvalid_q  <= 1'b0;
            busy_q    <= 1'b0;
            sel_ram_q <= 1'b0;
            wt_q      <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (bus.mem_wen) begin
                        state_q  <= ST_WRITE;
                        rvalid_q <= 1'b0;
                        busy_q   <= 1'b1;
                    end else if (bus.addr_reg_en) begin
                        state_q  <= ST_READ;
                        cnt_q    <= '0;
                        rvalid_q <= 1'b0;
                        busy_q   <= 1'b1;
                    end
                end
                ST_READ: begin
                    if (bus.mem_wen) begin
                        state_q <= ST_WRITE;
                    end else if (bus.addr_reg_en) begin
                        cnt_q <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q   <= ST_IDLE;
                        rvalid_q  <= 1'b1;
                        busy_q    <= 1'b0;
                        sel_ram_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 2'd1;
                    end
                end
                ST_WRITE: begin
                    wt_q      <= mdr_q;
                    sel_ram_q <= 1'b0;
                    if (bus.mem_wen) begin
                        state_q <= ST_WRITE;
                    end else if (bus.addr_reg_en) begin
                        state_q <= ST_READ;
                        cnt_q   <= '0;
                    end else begin
                        state_q  <= ST_IDLE;
                        rvalid_q <= 1'b1;
                        busy_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mem_rdata  = sel_ram_q ? ram_rdata[DATA_WIDTH-1:0] : wt_q;
    assign bus.mem_rvalid = rvalid_q;
    assign bus.mem_busy   = busy_q;
endmodule

// File: tb/tb_sap1_mem_responder.sv
// Self-checking bench for sap1_mem_responder with a behavioural RAM model.
module tb_sap1_mem_responder;
  localparam int AW = 8;
  localparam int DW = 16;
  localparam int RL = 2;

  logic clk = 1'b0;
  logic a_reset_n = 1'b0;
  int n_checks = 0;
  int n_fail = 0;
  logic [DW-1:0] model [int];

  always #5 clk = ~clk;

  sap1_mem_responder_if #(.DATA_WIDTH(DW)) mif ();

  sap1_mem_responder #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(RL)
  ) u_dut (
    .clk(clk), .a_reset_n(a_reset_n), .bus(mif.slave)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    mif.bus_data = {8'($urandom), a};
    mif.addr_reg_en = 1'b1;
    cyc();
    mif.addr_reg_en = 1'b0;
    mif.bus_data = d;
    mif.data_reg_en = 1'b1;
    mif.mem_wen = 1'b1;
    cyc();
    mif.data_reg_en = 1'b0;
    mif.mem_wen = 1'b0;
    cyc();
    model[int'(a)] = d;
  endtask

  task automatic start_read(input logic [AW-1:0] a);
    mif.bus_data = {8'($urandom), a};
    mif.addr_reg_en = 1'b1;
    cyc();
    mif.addr_reg_en = 1'b0;
  endtask

  task automatic wait_rvalid(output int k);
    k = 0;
    while (!mif.mem_rvalid && k < 8) begin
      cyc();
      k++;
    end
  endtask

  task automatic test_reset();
    a_reset_n = 1'b0;
    mif.bus_data = '0;
    mif.addr_reg_en = 1'b0;
    mif.data_reg_en = 1'b0;
    mif.mem_wen = 1'b0;
    repeat (2) cyc();
    a_reset_n = 1'b1;
    repeat (5) cyc();
    n_checks++;
    if ({mif.mem_rdata, mif.mem_rvalid, mif.mem_busy, mif.mem_error}
        !== 19'd0) begin
      n_fail++;
      $display("FAIL reset: rdata=%h rv=%b busy=%b err=%b, want all 0",
               mif.mem_rdata, mif.mem_rvalid, mif.mem_busy, mif.mem_error);
    end
  endtask

  task automatic test_write_read();
    int k;
    do_write(8'h05, 16'hA55A);
    n_checks++;
    if (mif.mem_rdata !== 16'hA55A || mif.mem_rvalid !== 1'b1 ||
        mif.mem_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL wr_through: rdata=%h rv=%b busy=%b, want a55a 1 0",
               mif.mem_rdata, mif.mem_rvalid, mif.mem_busy);
    end
    start_read(8'h05);
    n_checks++;
    if (mif.mem_rvalid !== 1'b0 || mif.mem_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL rd_start: rv=%b busy=%b, want 0 1",
               mif.mem_rvalid, mif.mem_busy);
    end
    wait_rvalid(k);
    n_checks++;
    if (k !== RL || mif.mem_rdata !== 16'hA55A || mif.mem_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rd_05: lat=%0d rdata=%h busy=%b, want %0d a55a 0",
               k, mif.mem_rdata, mif.mem_busy, RL);
    end
  endtask

  task automatic test_same_cycle();
    int k;
    do_write(8'hFF, 16'h1234);
    n_checks++;
    if (mif.mem_rdata !== 16'h1234 || mif.mem_rvalid !== 1'b1) begin
      n_fail++;
      $display("FAIL same_cyc_wt: rdata=%h rv=%b, want 1234 1",
               mif.mem_rdata, mif.mem_rvalid);
    end
    start_read(8'hFF);
    wait_rvalid(k);
    n_checks++;
    if (k !== RL || mif.mem_rdata !== 16'h1234) begin
      n_fail++;
      $display("FAIL same_cyc_rd: lat=%0d rdata=%h, want %0d 1234",
               k, mif.mem_rdata, RL);
    end
  endtask

  task automatic test_restart();
    int k;
    logic sawv;
    do_write(8'h03, 16'(($urandom & 16'h7FFF) | 16'h0001));
    do_write(8'h04, ~model[3]);
    start_read(8'h03);
    sawv = mif.mem_rvalid;
    start_read(8'h04);
    sawv = sawv | mif.mem_rvalid;
    wait_rvalid(k);
    n_checks++;
    if (sawv !== 1'b0 || k !== RL || mif.mem_rdata !== model[4]) begin
      n_fail++;
      $display("FAIL restart: early=%b lat=%0d rdata=%h, want 0 %0d %h",
               sawv, k, mif.mem_rdata, RL, model[4]);
    end
  endtask

  task automatic test_reset_abort();
    int k;
    do_write(8'h10, 16'h0F0F);
    mif.bus_data = 16'h0010;
    mif.addr_reg_en = 1'b1;
    cyc();
    mif.addr_reg_en = 1'b0;
    mif.bus_data = 16'hBEEF;
    mif.data_reg_en = 1'b1;
    mif.mem_wen = 1'b1;
    cyc();
    mif.data_reg_en = 1'b0;
    mif.mem_wen = 1'b0;
    n_checks++;
    if (mif.mem_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL wr_busy: busy=%b, want 1", mif.mem_busy);
    end
    a_reset_n = 1'b0;
    #2;
    n_checks++;
    if ({mif.mem_rdata, mif.mem_rvalid, mif.mem_busy} !== 18'd0) begin
      n_fail++;
      $display("FAIL async_rst: rdata=%h rv=%b busy=%b, want 0 0 0",
               mif.mem_rdata, mif.mem_rvalid, mif.mem_busy);
    end
    @(posedge clk);
    #1;
    a_reset_n = 1'b1;
    cyc();
    start_read(8'h10);
    wait_rvalid(k);
    n_checks++;
    if (k !== RL || mif.mem_rdata !== 16'h0F0F) begin
      n_fail++;
      $display("FAIL rst_abort: lat=%0d rdata=%h, want %0d 0f0f",
               k, mif.mem_rdata, RL);
    end
  endtask

  task automatic test_data_reg_en();
    logic [DW-1:0] held;
    held = mif.mem_rdata;
    mif.bus_data = 16'($urandom);
    mif.data_reg_en = 1'b1;
    cyc();
    mif.data_reg_en = 1'b0;
    cyc();
    n_checks++;
    if (mif.mem_rvalid !== 1'b1 || mif.mem_busy !== 1'b0 ||
        mif.mem_rdata !== held) begin
      n_fail++;
      $display("FAIL mdr_only: rv=%b busy=%b rdata=%h, want 1 0 %h",
               mif.mem_rvalid, mif.mem_busy, mif.mem_rdata, held);
    end
  endtask

  task automatic test_random();
    int k;
    int a;
    for (int i = 0; i < 40; i++) begin
      a = 8'h40 + int'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 0 || !model.exists(a)) begin
        do_write(8'(a), 16'($urandom));
        n_checks++;
        if (mif.mem_rdata !== model[a] || mif.mem_rvalid !== 1'b1) begin
          n_fail++;
          $display("FAIL rnd_wr[%0d]: rdata=%h rv=%b, want %h 1",
                   i, mif.mem_rdata, mif.mem_rvalid, model[a]);
        end
      end else begin
        start_read(8'(a));
        wait_rvalid(k);
        n_checks++;
        if (k !== RL || mif.mem_rdata !== model[a] ||
            mif.mem_error !== 1'b0) begin
          n_fail++;
          $display("FAIL rnd_rd[%0d]: lat=%0d rdata=%h err=%b, want %0d %h 0",
                   i, k, mif.mem_rdata, mif.mem_error, RL, model[a]);
        end
      end
    end
  endtask

`ifdef SAP1_MEM_PARITY_EN
  task automatic test_parity();
    int k;
    do_write(8'h20, 16'h5A5A);
    u_dut.u_ram.mem_q[8'h20][0] = ~u_dut.u_ram.mem_q[8'h20][0];
    start_read(8'h20);
    wait_rvalid(k);
    n_checks++;
    if (mif.mem_error !== 1'b1) begin
      n_fail++;
      $display("FAIL par_err: err=%b, want 1", mif.mem_error);
    end
    do_write(8'h21, 16'h0001);
    n_checks++;
    if (mif.mem_error !== 1'b0) begin
      n_fail++;
      $display("FAIL par_clr: err=%b, want 0", mif.mem_error);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_write_read();
    test_data_reg_en();
    test_same_cycle();
    test_restart();
    test_reset_abort();
    test_random();
`ifdef SAP1_MEM_PARITY_EN
    test_parity();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end
endmodule
